core_regs_mp: RTL and testbench
===============================

Name: core_regs_mp

Overview:
- Parametrised successor to the core general-purpose register file: configurable word width, register count, read-port count and write-port count.
- Reads are registered with one-cycle latency. R0 is hardwired to zero.
- Adds deterministic write-port priority on same-register collisions and a sequential post-reset clear sequencer, so the array can map onto RAM-style storage without a parallel reset.
- Sits between decode/issue (read addresses) and the writeback stage (write lines).

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of architectural registers; index 0 is R0. Legal range 2..256.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports.
- ADDR_W, $clog2(DEPTH), register index width. Derived; never overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_r  in  NUM_RD*ADDR_W  read register indices; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_value  out  NUM_RD*WIDTH  registered read data; port i occupies bits [i*WIDTH +: WIDTH].
- wr_ready  in  NUM_WR  per-port write enable.
- wr_rd  in  NUM_WR*ADDR_W  per-port destination index.
- wr_value  in  NUM_WR*WIDTH  per-port write data.
- busy  out  1  high while the clear sequence runs; the file accepts no writes and returns no data while high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rd_value <= 0 and busy <= 1.
  - Clear index <= 1; FSM enters CLEAR.
  - Reset takes priority over all other activity.
  - Reset asserted mid-CLEAR restarts the sequence at index 1.
- FSM CLEAR:
  - Each cycle, file[idx] <= 0 and idx increments.
  - When idx = DEPTH-1 is written, the next state is RUN and busy <= 0 on that same edge.
  - The sequence takes exactly DEPTH-1 cycles after reset is released.
  - wr_ready is ignored and rd_value is held at 0 during CLEAR.
- FSM RUN: normal operation; the FSM stays in RUN until the next reset.
- Writes (RUN only):
  - For each port j with wr_ready[j]=1, 0 < wr_rd[j] < DEPTH: file[wr_rd[j]] <= wr_value[j].
  - wr_rd = 0 is ignored, as is wr_rd >= DEPTH (possible when DEPTH is not a power of two).
  - Several ports targeting the same index in one cycle: the highest-numbered port wins. The others are dropped silently, with no error.
- Reads (RUN only):
  - rd_value[i] <= (rd_r[i] == 0 or rd_r[i] >= DEPTH) ? 0 : file[rd_r[i]].
  - Latency is 1 cycle: the address presented at edge N gives data valid after edge N+1.
  - rd_value holds its value until the next edge; there is no read enable.
- Read/write same index, same cycle: governed by the Optional Feature.
- Storage has no reset value beyond what the clear sequence writes. Simulation must show no X on rd_value once busy=0.

Optional Feature:
- Macro: CORE_REGS_BYPASS_EN.
- Defined:
  - Write-through forwarding. If a read index matches an enabled, legal, non-R0 write in the same cycle, rd_value gets the write data; with several matches, the highest-numbered port's data.
  - Result: a value written at edge N is visible on a read issued at edge N.
- Undefined:
  - Read-before-write. A same-cycle read returns the old contents; the new value is visible to reads issued from edge N+1 onward.

Test Plan:
- Clear sequence, DEPTH=32: assert rst for 2 cycles, then release -> busy stays high for exactly 31 cycles; once busy=0, reads of all indices return 0 with no X. A wr_ready pulse to r5 mid-CLEAR has no effect: r5 reads 0 afterward.
- Basic write/read: write r3=0xDEADBEEF on port 0, then read r3 on all 4 ports the next cycle -> all four rd_value show 0xDEADBEEF one cycle after the address is presented.
- R0 and out of range: write r0=0xFFFFFFFF -> r0 reads 0. With DEPTH=24, write index 30 -> no storage changes; reading index 30 returns 0.
- Collision: port 0 writes r7=0x11 and port 1 writes r7=0x22 in the same cycle -> r7 reads 0x22.
- Bypass: write r9=0xAA in the cycle r9 holds 0x55 and read r9 in that same cycle -> rd_value is 0xAA with CORE_REGS_BYPASS_EN defined, 0x55 without; the following read returns 0xAA in both builds.
- Reset mid-operation: run traffic, then assert rst for 1 cycle -> rd_value=0 and busy=1 on the next edge. After 31 further cycles, every register reads 0, including the previously written ones.

Source files
------------

// File: rtl/core_regs_mp.sv
// core_regs_mp: parametrised multi-port general-purpose register file.
//   clk       rising-edge clock
//   rst       synchronous active-high reset; starts the clear sequence
//   rd_r      NUM_RD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_value  NUM_RD packed registered read data, port i at [i*WIDTH +: WIDTH]
//   wr_ready  per-port write enable
//   wr_rd     NUM_WR packed destination indices
//   wr_value  NUM_WR packed write data
//   busy      high while the post-reset clear sequence runs
// R0 reads as zero. Storage has no parallel reset; after rst a sequencer
// zeroes R1..R(DEPTH-1), one per cycle. The highest-numbered write port wins
// a same-index collision.
// Build option CORE_REGS_BYPASS_EN: same-cycle write-through forwarding to
// reads. Without it, a read returns the contents from before the
// same-cycle write.

// Next-value logic for one read port: index legality plus optional forwarding.
module core_regs_rd_port #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]              addr,
  input  logic [WIDTH-1:0]               mem_q,
  input  logic [NUM_WR-1:0]              wr_ok,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_idx,
  input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]               rd_d
);
`ifndef CORE_REGS_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_ok, wr_idx, wr_data};
`endif

  always_comb begin
    rd_d = '0;
    if (addr != '0 && 32'(addr) < DEPTH) rd_d = mem_q;
`ifdef CORE_REGS_BYPASS_EN
    // wr_ok already excludes R0 and out-of-range indices; later ports override.
    for (int j = 0; j < int'(NUM_WR); j++)
      if (wr_ok[j] && wr_idx[j] == addr) rd_d = wr_data[j];
`endif
  end
endmodule

module core_regs_mp #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_r,
  output logic [NUM_RD*WIDTH-1:0]  rd_value,
  input  logic [NUM_WR-1:0]        wr_ready,
  input  logic [NUM_WR*ADDR_W-1:0] wr_rd,
  input  logic [NUM_WR*WIDTH-1:0]  wr_value,
  output logic                     busy
);
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                           state;
  logic [ADDR_W-1:0]                clr_idx;
  logic [WIDTH-1:0]                 mem [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_a;
  logic [NUM_RD-1:0][WIDTH-1:0]     mem_q, rd_d, rd_q;
  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_a;
  logic [NUM_WR-1:0][WIDTH-1:0]     wr_d;
  logic [NUM_WR-1:0]                wr_ok;

  assign rd_a     = rd_r;
  assign wr_a     = wr_rd;
  assign wr_d     = wr_value;
  assign rd_value = rd_q;

  genvar j, i;
  generate
    for (j = 0; j < NUM_WR; j++) begin : g_wr
      assign wr_ok[j] = (state == S_RUN) && wr_ready[j] &&
                        wr_a[j] != '0 && 32'(wr_a[j]) < DEPTH;
    end
    for (i = 0; i < NUM_RD; i++) begin : g_rd
      // Out-of-range indices are masked to zero inside the port logic.
      assign mem_q[i] = mem[rd_a[i]];
      core_regs_rd_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .ADDR_W(ADDR_W)
      ) u_rd (
        .addr(rd_a[i]), .mem_q(mem_q[i]), .wr_ok(wr_ok),
        .wr_idx(wr_a), .wr_data(wr_d), .rd_d(rd_d[i])
      );
    end
  endgenerate

  // Storage: no reset term, so this maps onto RAM-style arrays.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) mem[clr_idx] <= '0;
      else
        for (int k = 0; k < int'(NUM_WR); k++)
          if (wr_ok[k]) mem[wr_a[k]] <= wr_d[k];  // later port wins
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_idx <= ADDR_W'(1);
      busy    <= 1'b1;
      rd_q    <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          rd_q <= '0;
          if (32'(clr_idx) == DEPTH - 1) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: rd_q <= rd_d;
      endcase
    end
  end
endmodule

// File: tb/tb_core_regs_mp.sv
module tb_core_regs_mp;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0][4:0]  rd_r = '0;
  logic [3:0][31:0] rd_value;
  logic [1:0]       wr_ready = '0;
  logic [1:0][4:0]  wr_rd = '0;
  logic [1:0][31:0] wr_value = '0;
  logic             busy;

  // Second instance with a non-power-of-two depth for range checks.
  logic [3:0][4:0]  rd2_r = '0;
  logic [3:0][31:0] rd2_value;
  logic [1:0]       wr2_ready = '0;
  logic [1:0][4:0]  wr2_rd = '0;
  logic [1:0][31:0] wr2_value = '0;
  logic             busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_regs_mp dut (
    .clk(clk), .rst(rst), .rd_r(rd_r), .rd_value(rd_value),
    .wr_ready(wr_ready), .wr_rd(wr_rd), .wr_value(wr_value), .busy(busy)
  );

  core_regs_mp #(.DEPTH(24)) dut24 (
    .clk(clk), .rst(rst), .rd_r(rd2_r), .rd_value(rd2_value),
    .wr_ready(wr2_ready), .wr_rd(wr2_rd), .wr_value(wr2_value), .busy(busy2)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int p, input logic [4:0] idx, input logic [31:0] v);
    wr_ready[p] = 1'b1; wr_rd[p] = idx; wr_value[p] = v;
    step();
    wr_ready = '0;
  endtask

  task automatic rd_all(input logic [4:0] idx);
    for (int p = 0; p < 4; p++) rd_r[p] = idx;
    step();
  endtask

  task automatic test_reset();
    int n, n2;
    rst = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++;
    if (rd_value !== '0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd_value); end
    rst = 1'b0;
    n = 0; n2 = -1;
    while (busy === 1'b1 && n < 100) begin
      if (n == 10) begin
        wr_ready[0] = 1'b1; wr_rd[0] = 5'd5; wr_value[0] = 32'h1234;
      end else wr_ready = '0;
      for (int p = 0; p < 4; p++) rd_r[p] = 5'd5;
      step();
      n++;
      if (busy2 !== 1'b1 && n2 < 0) n2 = n;
      if (n == 15) begin
        checks++;
        if (rd_value !== '0) begin errors++; $display("FAIL clear_rd_held got=%h exp=0", rd_value); end
      end
    end
    wr_ready = '0;
    checks++;
    if (n != 31) begin errors++; $display("FAIL clear_len got=%0d exp=31", n); end
    checks++;
    if (n2 != 23) begin errors++; $display("FAIL clear_len24 got=%0d exp=23", n2); end
    for (int b = 0; b < 32; b += 4) begin
      for (int p = 0; p < 4; p++) rd_r[p] = 5'(b + p);
      step();
      checks++;
      if (rd_value !== '0) begin errors++; $display("FAIL clear_zero base=%0d got=%h exp=0", b, rd_value); end
    end
  endtask

  task automatic test_basic();
    wr(0, 5'd3, 32'hDEADBEEF);
    rd_all(5'd3);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_value[p] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL basic_rd port=%0d got=%h exp=deadbeef", p, rd_value[p]);
      end
    end
    wr_ready = 2'b11; wr_rd[0] = 5'd10; wr_value[0] = 32'h100;
    wr_rd[1] = 5'd11; wr_value[1] = 32'h200;
    step();
    wr_ready = '0;
    rd_r[0] = 5'd10; rd_r[1] = 5'd11; rd_r[2] = 5'd0; rd_r[3] = 5'd3;
    step();
    checks++;
    if (rd_value !== {32'hDEADBEEF, 32'h0, 32'h200, 32'h100}) begin
      errors++; $display("FAIL dual_wr got=%h", rd_value);
    end
  endtask

  task automatic test_r0_range();
    wr(0, 5'd0, 32'hFFFFFFFF);
    wr(1, 5'd0, 32'hFFFFFFFF);
    rd_all(5'd0);
    checks++;
    if (rd_value !== '0) begin errors++; $display("FAIL r0 got=%h exp=0", rd_value); end
    wr2_ready = 2'b11; wr2_rd[0] = 5'd3; wr2_value[0] = 32'h77;
    wr2_rd[1] = 5'd30; wr2_value[1] = 32'hBAD;
    step();
    wr2_ready = '0;
    rd2_r[0] = 5'd30; rd2_r[1] = 5'd3; rd2_r[2] = 5'd6; rd2_r[3] = 5'd14;
    step();
    checks++;
    if (rd2_value !== {32'h0, 32'h0, 32'h77, 32'h0}) begin
      errors++; $display("FAIL range24 got=%h exp=0_0_77_0", rd2_value);
    end
  endtask

  task automatic test_collision();
    wr_ready = 2'b11; wr_rd[0] = 5'd7; wr_rd[1] = 5'd7;
    wr_value[0] = 32'h11; wr_value[1] = 32'h22;
    step();
    wr_ready = '0;
    rd_all(5'd7);
    checks++;
    if (rd_value[2] !== 32'h22) begin errors++; $display("FAIL collide got=%h exp=22", rd_value[2]); end
    wr_ready = 2'b11; wr_value[0] = 32'h44; wr_value[1] = 32'h33;
    step();
    wr_ready = '0;
    rd_all(5'd7);
    checks++;
    if (rd_value[0] !== 32'h33) begin errors++; $display("FAIL collide2 got=%h exp=33", rd_value[0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    wr(0, 5'd9, 32'h55);
`ifdef CORE_REGS_BYPASS_EN
    exp = 32'hAA;
`else
    exp = 32'h55;
`endif
    wr_ready[1] = 1'b1; wr_rd[1] = 5'd9; wr_value[1] = 32'hAA;
    for (int p = 0; p < 4; p++) rd_r[p] = 5'd9;
    step();
    wr_ready = '0;
    checks++;
    if (rd_value[1] !== exp) begin errors++; $display("FAIL bypass_same got=%h exp=%h", rd_value[1], exp); end
    step();
    checks++;
    if (rd_value[3] !== 32'hAA) begin errors++; $display("FAIL bypass_next got=%h exp=aa", rd_value[3]); end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    step();
    checks++;
    if (rd_value !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset got rd=%h busy=%b exp rd=0 busy=1", rd_value, busy);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n != 31) begin errors++; $display("FAIL mid_clear_len got=%0d exp=31", n); end
    rd_r[0] = 5'd3; rd_r[1] = 5'd7; rd_r[2] = 5'd9; rd_r[3] = 5'd10;
    step();
    checks++;
    if (rd_value !== '0) begin errors++; $display("FAIL mid_cleared got=%h exp=0", rd_value); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_r0_range();
    test_collision();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
